// File: rtl/nibble_serial_sub.sv
// rtl/nibble_serial_sub.sv - nibble-serial subtractor computing A-B-bin one 4-bit slice per cycle
//
// Optional feature macro: NIBBLE_SUB_OVF_EN (adds signed-overflow output V)
//
// Ports:
//   clk       - clock, all state changes on rising edge
//   rst       - synchronous active-high reset
//   in_valid  - operands A, B, bin presented
//   in_ready  - unit accepts operands this cycle (IDLE only)
//   A, B      - minuend and subtraend, WIDTH bits
//   bin       - borrow-in
//   out_valid - R, bout, Z (and V) valid (DONE only)
//   out_ready - consumer takes the result
//   R         - difference A-B-bin mod 2^WIDTH
//   bout      - borrow-out, 1 when A < B+bin (unsigned)
//   Z         - 1 when R is zero
//   V         - signed overflow (only with NIBBLE_SUB_OVF_EN)

module nibble_serial_sub #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             bout,
`ifdef NIBBLE_SUB_OVF_EN
    output logic             V,
`endif
    output logic             Z
);

    localparam int NIBS = WIDTH / 4;
    localparam int CW   = $clog2(NIBS);
    localparam logic [CW-1:0] LAST = CW'(NIBS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             z_reg;
`ifdef NIBBLE_SUB_OVF_EN
    logic             v_reg;
`endif

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       sum;
    logic [WIDTH-1:0] r_next;
    logic             last_slice;

    // Slice datapath: subtraction as a + ~b + carry, where carry-in is the
    // inverted borrow and the carry-out inverted is the next borrow.
    always_comb begin
        a_nib      = a_reg[{cnt, 2'b00} +: 4];
        b_nib      = b_reg[{cnt, 2'b00} +: 4];
        sum        = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, ~borrow};
        r_next     = r_reg;
        r_next[{cnt, 2'b00} +: 4] = sum[3:0];
        last_slice = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            r_reg  <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            z_reg  <= 1'b0;
`ifdef NIBBLE_SUB_OVF_EN
            v_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= A;
                        b_reg  <= B;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    r_reg  <= r_next;
                    borrow <= ~sum[4];
                    cnt    <= cnt + 1'b1;
                    // Flags are taken from the complete result as the top
                    // nibble lands, so they are ready together with R.
                    if (last_slice) begin
                        cnt   <= '0;
                        z_reg <= (r_next == '0);
`ifdef NIBBLE_SUB_OVF_EN
                        v_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                                 (r_next[WIDTH-1] != a_reg[WIDTH-1]);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign R    = r_reg;
    assign bout = borrow;
    assign Z    = z_reg;
`ifdef NIBBLE_SUB_OVF_EN
    assign V    = v_reg;
`endif

endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb/tb_nibble_serial_sub.sv - self-checking bench for nibble_serial_sub (WIDTH=64)

module tb_nibble_serial_sub;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] R;
    logic        bout;
    logic        Z;
`ifdef NIBBLE_SUB_OVF_EN
    logic        V;
`endif

    int errors = 0;
    int checks = 0;

    nibble_serial_sub #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .bout      (bout),
`ifdef NIBBLE_SUB_OVF_EN
        .V         (V),
`endif
        .Z         (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bi;
        logic [63:0] r;
        logic        bo;
        logic        z;
        logic        v;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present operands, wait for out_valid and check latency and results.
    // Returns at a negedge with out_valid high (or after the budget expires).
    task automatic start_and_wait(input logic [63:0] a, input logic [63:0] b, input logic bi,
                                  input string tag);
        int lat;
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        A = a; B = b; bin = bi; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        A = '1; B = '1; bin = 1'b1;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        chk({tag, " latency"}, 64'(lat), 64'd16);
    endtask

    task automatic check_result(input vec_t t, input string tag);
        chk({tag, " R"}, R, t.r);
        chk({tag, " bout"}, 64'(bout), 64'(t.bo));
        chk({tag, " Z"}, 64'(Z), 64'(t.z));
`ifdef NIBBLE_SUB_OVF_EN
        chk({tag, " V"}, 64'(V), 64'(t.v));
`endif
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid after take"}, 64'(out_valid), 64'd0);
        chk({tag, " in_ready after take"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        vec_t bp;
        vec_t zz;
        logic [63:0] r_hold;

        vecs[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{64'd10, 64'd3, 1'b1, 64'd6, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{64'h0123_4567_89AB_CDEF, 64'h0011_2233_4455_6677, 1'b0, 64'h0112_2334_4556_6778, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset R", R, 64'd0);
        chk("reset bout", 64'(bout), 64'd0);
        chk("reset Z", 64'(Z), 64'd0);
`ifdef NIBBLE_SUB_OVF_EN
        chk("reset V", 64'(V), 64'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            start_and_wait(vecs[i].a, vecs[i].b, vecs[i].bi, tag);
            check_result(vecs[i], tag);
            handshake(tag);
        end

        // Backpressure: hold out_ready low in DONE with a competing request.
        bp = '{64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0002, 1'b0,
               64'hDEAD_BEEE_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        start_and_wait(bp.a, bp.b, bp.bi, "bp");
        r_hold = R;
        A = 64'd7; B = 64'd1; bin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp R stable", R, r_hold);
            check_result(bp, "bp");
        end
        in_valid = 1'b0;
        handshake("bp");

        // Reset while slice 7 is in flight.
        @(negedge clk);
        A = 64'h1111_2222_3333_4444; B = 64'h0000_0000_0000_0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst R", R, 64'd0);
        chk("midrst bout", 64'(bout), 64'd0);

        zz = '{64'h10, 64'h10, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0};
        start_and_wait(zz.a, zz.b, zz.bi, "postrst");
        check_result(zz, "postrst");
        handshake("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
